// File: rtl/stream_fifo_clearable.sv
// Single-clock valid/ready FIFO with a clear handshake that flushes the buffer
// and isolates both ports for CLEAR_HOLD cycles. Define STREAM_FIFO_CLEARABLE_DROP_CNT_EN
// to add a saturating 16-bit count of items discarded by clears (drop_cnt_o).
module stream_fifo_clearable #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CLEAR_HOLD = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    output logic                         clear_pending_o,
    input  logic [DATA_WIDTH-1:0]        in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
`ifdef STREAM_FIFO_CLEARABLE_DROP_CNT_EN
    output logic [15:0]                  drop_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned USE_W = $clog2(DEPTH+1);
    localparam int unsigned CNT_W = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [USE_W-1:0] use_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

    state_e                state_q, state_d;
    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    use_t                  usage_q, usage_d;
    cnt_t                  hold_cnt_q, hold_cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic in_ready, out_valid, push, pop, full, empty;

`ifdef STREAM_FIFO_CLEARABLE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [15:0] sat_add(input logic [15:0] acc, input use_t inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction
`endif

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH-1)) ? '0 : ptr_t'(p + ptr_t'(1));
    endfunction

    assign full  = (usage_q == use_t'(DEPTH));
    assign empty = (usage_q == '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        usage_d    = usage_q;
        hold_cnt_d = hold_cnt_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
`ifdef STREAM_FIFO_CLEARABLE_DROP_CNT_EN
        drop_cnt_d = drop_cnt_q;
`endif
        case (state_q)
            RUN: begin
                in_ready  = !full && !clear_i;
                out_valid = !empty && !clear_i;
                push      = in_valid_i && in_ready;
                pop       = out_valid && out_ready_i;
                if (clear_i) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    usage_d    = '0;
                    hold_cnt_d = cnt_t'(CLEAR_HOLD-1);
                    state_d    = HOLD;
`ifdef STREAM_FIFO_CLEARABLE_DROP_CNT_EN
                    drop_cnt_d = sat_add(drop_cnt_q, usage_q);
`endif
                end else begin
                    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
                    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
                    case ({push, pop})
                        2'b10:   usage_d = usage_q + use_t'(1);
                        2'b01:   usage_d = usage_q - use_t'(1);
                        default: usage_d = usage_q;
                    endcase
                    // Register the next head; a lone item written this cycle is forwarded
                    // from the input since the memory write lands on the same edge.
                    if (usage_d != '0)
                        out_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? in_data_i : mem_q[rd_ptr_d];
                end
            end
            HOLD: begin
                if (clear_i) begin
                    hold_cnt_d = cnt_t'(CLEAR_HOLD-1);
`ifdef STREAM_FIFO_CLEARABLE_DROP_CNT_EN
                    drop_cnt_d = sat_add(drop_cnt_q, usage_q);
`endif
                end else if (hold_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - cnt_t'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usage_q    <= '0;
            hold_cnt_q <= '0;
            out_data_q <= '0;
`ifdef STREAM_FIFO_CLEARABLE_DROP_CNT_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usage_q    <= usage_d;
            hold_cnt_q <= hold_cnt_d;
            out_data_q <= out_data_d;
`ifdef STREAM_FIFO_CLEARABLE_DROP_CNT_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    // Storage carries no reset; stale contents are never exposed because out_data_q gates them.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

    assign in_ready_o      = in_ready;
    assign out_valid_o     = out_valid;
    assign out_data_o      = out_data_q;
    assign usage_o         = usage_q;
    assign clear_pending_o = (state_q == HOLD);
`ifdef STREAM_FIFO_CLEARABLE_DROP_CNT_EN
    assign drop_cnt_o      = drop_cnt_q;
`endif

    a_usage_range: assert property (@(posedge clk_i) disable iff (!rst_ni) usage_q <= use_t'(DEPTH));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !full);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> !empty);

endmodule
